// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, response error codes and FSM states.
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_B   = 2'b00,
        SIZE_H   = 2'b01,
        SIZE_W   = 2'b10,
        SIZE_ILL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BEAT0 = 2'b01,
        ST_BEAT1 = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    // Bytes touched by an access; 0 for the illegal encoding.
    function automatic int size_bytes(input logic [1:0] size);
        case (size)
            SIZE_B:  return 1;
            SIZE_H:  return 2;
            SIZE_W:  return 4;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: builds store masks/data for both beats from the address offset,
// and assembles/extends load data from the two beat words.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [OFF_W-1:0]  off,
    input  logic [1:0]        size,
    input  logic              sign,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   lo_data,
    input  logic [XLEN-1:0]   hi_data,
    output logic [XLEN/8-1:0] wmask0,
    output logic [XLEN/8-1:0] wmask1,
    output logic [XLEN-1:0]   wdata0,
    output logic [XLEN-1:0]   wdata1,
    output logic [XLEN-1:0]   ldata
);
    localparam int NB = XLEN / 8;

    int                nbytes;
    logic [NB-1:0]     smask;
    logic [2*NB-1:0]   mask_wide;
    logic [2*XLEN-1:0] data_wide;
    logic [XLEN-1:0]   shifted;
    logic              msb;

    // The upper half of each double-width shift is what spills into the second beat.
    always_comb begin
        nbytes = size_bytes(size);
        smask  = '0;
        for (int i = 0; i < NB; i++) smask[i] = (i < nbytes);
        mask_wide = {{NB{1'b0}}, smask} << off;
        data_wide = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
        shifted   = XLEN'({hi_data, lo_data} >> {off, 3'b000});
        case (size)
            SIZE_B:  msb = shifted[7];
            SIZE_H:  msb = shifted[15];
            default: msb = shifted[31];
        endcase
        for (int i = 0; i < XLEN; i++) ldata[i] = (i < 8 * nbytes) ? shifted[i] : (sign & msb);
    end

    assign wmask0 = mask_wide[NB-1:0];
    assign wmask1 = mask_wide[2*NB-1:NB];
    assign wdata0 = data_wide[XLEN-1:0];
    assign wdata1 = data_wide[2*XLEN-1:XLEN];

endmodule

// File: rtl/lsu_split_access.sv
// MEM-stage load/store unit: variable-latency req/rvalid memory port, word-crossing
// accesses split into two beats, per-beat timeout, registered one-cycle response.
module lsu_split_access
    import lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 11,
    parameter bit MISALIGN_SPLIT = 1'b1,
    parameter int TIMEOUT_CYC    = 255
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_wen_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_sign_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    input  logic [4:0]        req_rd_i,
    output logic              stall_o,
    output logic              rsp_valid_o,
    output logic [XLEN-1:0]   rsp_rdata_o,
    output logic [4:0]        rsp_rd_o,
    output logic [1:0]        rsp_err_o,
    output logic              mem_req_o,
    output logic              mem_wen_o,
    output logic [XLEN/8-1:0] mem_wmask_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef struct packed {
        logic              req;
        logic              wen;
        logic [NB-1:0]     wmask;
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   wdata;
    } mem_beat_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] rdata;
        logic [4:0]      rd;
        err_e            err;
    } rsp_t;

    typedef struct packed {
        logic             wen;
        logic             sign;
        logic [1:0]       size;
        logic [OFF_W-1:0] off;
        logic             crossing;
        logic [4:0]       rd;
        logic [NB-1:0]    wmask1;
        logic [XLEN-1:0]  wdata1;
    } ctx_t;

    function automatic rsp_t make_rsp(input logic [XLEN-1:0] rdata, input logic [4:0] rd, input err_e err);
        rsp_t r;
        r.valid = 1'b1;
        r.rdata = rdata;
        r.rd    = rd;
        r.err   = err;
        return r;
    endfunction

    state_e          state_q, state_d;
    ctx_t            ctx_q, ctx_d;
    mem_beat_t       mem_q, mem_d;
    rsp_t            rsp_q, rsp_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [CNT_W-1:0] wait_q, wait_d;

    logic [OFF_W-1:0] req_off, align_off;
    logic [1:0]       align_size;
    logic             req_crossing, timeout_hit;
    logic [NB-1:0]    wmask0, wmask1;
    logic [XLEN-1:0]  wdata0, wdata1, ldata, lo_sel;

    assign req_off      = req_addr_i[OFF_W-1:0];
    assign req_crossing = (int'(req_off) + size_bytes(req_size_i)) > NB;
    assign timeout_hit  = (TIMEOUT_CYC != 0) && (wait_q == CNT_W'(TIMEOUT_CYC - 1));

    // Store steering is only consumed on accept; load assembly only while a beat completes.
    assign align_off  = (state_q == ST_IDLE) ? req_off : ctx_q.off;
    assign align_size = (state_q == ST_IDLE) ? req_size_i : ctx_q.size;
    assign lo_sel     = (state_q == ST_BEAT1) ? lo_q : mem_rdata_i;

    lsu_align #(.XLEN(XLEN), .OFF_W(OFF_W)) u_align (
        .off     (align_off),
        .size    (align_size),
        .sign    (ctx_q.sign),
        .wdata   (req_wdata_i),
        .lo_data (lo_sel),
        .hi_data (mem_rdata_i),
        .wmask0  (wmask0),
        .wmask1  (wmask1),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .ldata   (ldata)
    );

    // NOTE: every combinational output is given a default before the case so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        ctx_d     = ctx_q;
        mem_d     = mem_q;
        rsp_d     = rsp_q;
        rsp_d.valid = 1'b0;
        lo_d      = lo_q;
        wait_d    = wait_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    ctx_d = '{wen: req_wen_i, sign: req_sign_i, size: req_size_i, off: req_off,
                              crossing: req_crossing, rd: req_rd_i, wmask1: wmask1, wdata1: wdata1};
                    if (req_size_i == SIZE_ILL) begin
                        state_d = ST_RESP;
                        rsp_d   = make_rsp('0, req_rd_i, ERR_ILLEGAL);
                    end else if (req_crossing && !MISALIGN_SPLIT) begin
                        state_d = ST_RESP;
                        rsp_d   = make_rsp('0, req_rd_i, ERR_MISALIGN);
                    end else begin
                        state_d = ST_BEAT0;
                        mem_d   = '{req: 1'b1, wen: req_wen_i, wmask: wmask0,
                                    addr: {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}}, wdata: wdata0};
                        wait_d  = '0;
                    end
                end
            end
            ST_BEAT0, ST_BEAT1: begin
                if (mem_rvalid_i) begin
                    if (state_q == ST_BEAT0) lo_d = mem_rdata_i;
                    if (state_q == ST_BEAT0 && ctx_q.crossing) begin
                        state_d     = ST_BEAT1;
                        mem_d.addr  = mem_q.addr + ADDR_W'(NB);
                        mem_d.wmask = ctx_q.wmask1;
                        mem_d.wdata = ctx_q.wdata1;
                        wait_d      = '0;
                    end else begin
                        state_d   = ST_RESP;
                        mem_d.req = 1'b0;
                        mem_d.wen = 1'b1;
                        rsp_d     = make_rsp(ctx_q.wen ? ldata : '0, ctx_q.rd, ERR_OK);
                    end
                end else if (timeout_hit) begin
                    state_d   = ST_RESP;
                    mem_d.req = 1'b0;
                    mem_d.wen = 1'b1;
                    rsp_d     = make_rsp('0, ctx_q.rd, ERR_TIMEOUT);
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q   <= ST_IDLE;
            ctx_q     <= '0;
            mem_q     <= '0;
            mem_q.wen <= 1'b1;
            rsp_q     <= '0;
            lo_q      <= '0;
            wait_q    <= '0;
        end else begin
            state_q <= state_d;
            ctx_q   <= ctx_d;
            mem_q   <= mem_d;
            rsp_q   <= rsp_d;
            lo_q    <= lo_d;
            wait_q  <= wait_d;
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign stall_o     = ~req_ready_o & (state_q != ST_RESP);
    assign rsp_valid_o = rsp_q.valid;
    assign rsp_rdata_o = rsp_q.rdata;
    assign rsp_rd_o    = rsp_q.rd;
    assign rsp_err_o   = rsp_q.err;
    assign mem_req_o   = mem_q.req;
    assign mem_wen_o   = mem_q.wen;
    assign mem_wmask_o = mem_q.wmask;
    assign mem_addr_o  = mem_q.addr;
    assign mem_wdata_o = mem_q.wdata;

endmodule

// File: tb/tb_lsu_split_access.sv
// Scoreboard bench for lsu_split_access: byte-level reference memory predicts every response.
module tb_lsu_split_access;

    logic        clk_i, reset_i;
    logic        req_valid_i, req_ready_o, req_wen_i, req_sign_i;
    logic [1:0]  req_size_i;
    logic [10:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [4:0]  req_rd_i;
    logic        stall_o, rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic [4:0]  rsp_rd_o;
    logic [1:0]  rsp_err_o;
    logic        mem_req_o, mem_wen_o, mem_rvalid_i;
    logic [3:0]  mem_wmask_o;
    logic [10:0] mem_addr_o;
    logic [31:0] mem_wdata_o, mem_rdata_i;

    lsu_split_access #(.XLEN(32), .ADDR_W(11), .MISALIGN_SPLIT(1'b1), .TIMEOUT_CYC(255)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wen_i(req_wen_i),
        .req_size_i(req_size_i), .req_sign_i(req_sign_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i), .stall_o(stall_o),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_rd_o(rsp_rd_o), .rsp_err_o(rsp_err_o),
        .mem_req_o(mem_req_o), .mem_wen_o(mem_wen_o), .mem_wmask_o(mem_wmask_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic [1:0]  err;
    } exp_t;

    typedef struct {
        logic [10:0] addr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic        wen;
    } beat_t;

    exp_t        rsp_q[$];
    beat_t       beat_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          req_cycles = 0;
    logic [7:0]  mem [2048];
    logic [7:0]  ref_mem [2048];
    bit          mem_init_done = 1'b0;
    logic [1:0]  rv_mode;          // 0 zero-wait, 1 random wait, 2 never
    logic        rv_force, rv_gate;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [10:0] a);
        return 8'(a * 37 + 5);
    endfunction

    function automatic logic [31:0] ref_load(input logic [10:0] addr, input logic [1:0] size, input logic sign);
        int          n;
        logic [31:0] v;
        logic [10:0] a;
        n = 1 << size;
        v = '0;
        for (int i = 0; i < n; i++) begin
            a = addr + 11'(i);
            v[8*i +: 8] = ref_mem[a];
        end
        if (sign && n == 1) v = {{24{v[7]}}, v[7:0]};
        if (sign && n == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    assign mem_rvalid_i = rv_force | (mem_req_o & ((rv_mode == 2'd0) | ((rv_mode == 2'd1) & rv_gate)));

    always_comb begin
        mem_rdata_i = '0;
        for (int i = 0; i < 4; i++) mem_rdata_i[8*i +: 8] = mem[{mem_addr_o[10:2], 2'(i)}];
    end

    always @(posedge clk_i) begin
        #1;
        rv_gate = 1'($urandom_range(0, 1));
    end

    // Memory model: a beat completing at the next edge is committed here, away from the edge.
    always @(negedge clk_i) begin
        if (!mem_init_done) begin
            for (int a = 0; a < 2048; a++) mem[a] = init_byte(11'(a));
            mem_init_done = 1'b1;
        end else if (mem_req_o && mem_rvalid_i && !mem_wen_o) begin
            for (int i = 0; i < 4; i++)
                if (mem_wmask_o[i]) mem[{mem_addr_o[10:2], 2'(i)}] = mem_wdata_o[8*i +: 8];
        end
    end

    always @(negedge clk_i) begin
        exp_t e;
        if (mem_req_o === 1'b1) req_cycles++;
        if (mem_req_o === 1'b1 && mem_rvalid_i === 1'b1)
            beat_q.push_back('{addr: mem_addr_o, wmask: mem_wmask_o, wdata: mem_wdata_o, wen: mem_wen_o});
        if (rsp_valid_o === 1'b1) begin
            check("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
            check("stall_in_resp", 32'(stall_o), 32'd0);
            if (rsp_q.size() != 0) begin
                e = rsp_q.pop_front();
                check("rsp_rdata", rsp_rdata_o, e.rdata);
                check("rsp_rd", 32'(rsp_rd_o), 32'(e.rd));
                check("rsp_err", 32'(rsp_err_o), 32'(e.err));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready_o && n < 1000) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("ready_bound", 32'(req_ready_o), 32'd1);
    endtask

    task automatic access(input logic wen, input logic [1:0] size, input logic sign, input logic [10:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd, output int lat);
        exp_t e;
        int   n;
        wait_ready();
        n = (size == 2'b11) ? 0 : (1 << size);
        e.rd    = rd;
        e.rdata = '0;
        if (size == 2'b11) e.err = 2'b11;
        else if (rv_mode == 2'd2) e.err = 2'b10;
        else begin
            e.err = 2'b00;
            if (!wen) begin
                for (int i = 0; i < n; i++) ref_mem[addr + 11'(i)] = wdata[8*i +: 8];
            end else begin
                e.rdata = ref_load(addr, size, sign);
            end
        end
        rsp_q.push_back(e);
        req_valid_i = 1'b1; req_wen_i = wen; req_size_i = size; req_sign_i = sign;
        req_addr_i = addr; req_wdata_i = wdata; req_rd_i = rd;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        check("stall_after_accept", 32'(stall_o), 32'(size != 2'b11));
        check("mem_req_after_accept", 32'(mem_req_o), 32'(size != 2'b11));
        lat = 1;
        while (!req_ready_o && lat < 1000) begin
            @(posedge clk_i); #1;
            lat++;
        end
        check("ready_bound", 32'(req_ready_o), 32'd1);
    endtask

    initial begin
        int lat, base, rc;
        logic [1:0] sz;
        logic [10:0] ad;
        reset_i = 1'b0; req_valid_i = 1'b0; req_wen_i = 1'b1; req_size_i = '0; req_sign_i = 1'b0;
        req_addr_i = '0; req_wdata_i = '0; req_rd_i = '0;
        rv_mode = 2'd0; rv_force = 1'b0;
        for (int a = 0; a < 2048; a++) ref_mem[a] = init_byte(11'(a));
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_ready", 32'(req_ready_o), 32'd1);
        check("rst_mem_req", 32'(mem_req_o), 32'd0);
        check("rst_mem_wen", 32'(mem_wen_o), 32'd1);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_outputs", {mem_wmask_o, mem_addr_o, rsp_rd_o, rsp_err_o}, 32'd0);
        check("rst_wdata", mem_wdata_o, 32'd0);
        check("rst_rdata", rsp_rdata_o, 32'd0);
        @(posedge clk_i); #1;
        reset_i = 1'b1;

        // Aligned word store, zero-wait.
        base = beat_q.size();
        access(1'b0, 2'b10, 1'b0, 11'h010, 32'hDEADBEEF, 5'd1, lat);
        check("sw_latency", 32'(lat), 32'd3);
        check("sw_beats", 32'(beat_q.size() - base), 32'd1);
        check("sw_addr", 32'(beat_q[base].addr), 32'h010);
        check("sw_wmask", 32'(beat_q[base].wmask), 32'hF);
        check("sw_wdata", beat_q[base].wdata, 32'hDEADBEEF);
        check("sw_wen", 32'(beat_q[base].wen), 32'd0);

        // Byte 0x80 at 0x13, then signed and unsigned byte loads.
        base = beat_q.size();
        access(1'b0, 2'b00, 1'b0, 11'h013, 32'h00000080, 5'd2, lat);
        check("sb_wmask", 32'(beat_q[base].wmask), 32'h8);
        check("sb_wdata", beat_q[base].wdata, 32'h80000000);
        access(1'b1, 2'b00, 1'b1, 11'h013, 32'h0, 5'd3, lat);
        access(1'b1, 2'b00, 1'b0, 11'h013, 32'h0, 5'd4, lat);
        access(1'b1, 2'b01, 1'b1, 11'h012, 32'h0, 5'd5, lat);

        // Crossing word store at 0x06.
        base = beat_q.size();
        access(1'b0, 2'b10, 1'b0, 11'h006, 32'h11223344, 5'd6, lat);
        check("xsw_latency", 32'(lat), 32'd4);
        check("xsw_beats", 32'(beat_q.size() - base), 32'd2);
        check("xsw_b0_addr", 32'(beat_q[base].addr), 32'h004);
        check("xsw_b0_wmask", 32'(beat_q[base].wmask), 32'hC);
        check("xsw_b0_wdata", beat_q[base].wdata, 32'h33440000);
        check("xsw_b1_addr", 32'(beat_q[base+1].addr), 32'h008);
        check("xsw_b1_wmask", 32'(beat_q[base+1].wmask), 32'h3);
        check("xsw_b1_wdata", beat_q[base+1].wdata, 32'h00001122);
        access(1'b1, 2'b10, 1'b0, 11'h004, 32'h0, 5'd7, lat);
        access(1'b1, 2'b10, 1'b0, 11'h008, 32'h0, 5'd8, lat);
        access(1'b1, 2'b01, 1'b1, 11'h007, 32'h0, 5'd9, lat);

        // Word load at the top of memory wraps to address 0.
        access(1'b0, 2'b10, 1'b0, 11'h7FC, 32'hA1B2C3D4, 5'd10, lat);
        access(1'b0, 2'b10, 1'b0, 11'h000, 32'h55667788, 5'd11, lat);
        base = beat_q.size();
        access(1'b1, 2'b10, 1'b0, 11'h7FF, 32'h0, 5'd12, lat);
        check("wrap_latency", 32'(lat), 32'd4);
        check("wrap_b0_addr", 32'(beat_q[base].addr), 32'h7FC);
        check("wrap_b1_addr", 32'(beat_q[base+1].addr), 32'h000);

        // Timeouts: aligned and crossing loads with rvalid withheld.
        rv_mode = 2'd2;
        rc = req_cycles; base = beat_q.size();
        access(1'b1, 2'b10, 1'b0, 11'h020, 32'h0, 5'd13, lat);
        check("to_req_cycles", 32'(req_cycles - rc), 32'd255);
        rc = req_cycles;
        access(1'b1, 2'b10, 1'b0, 11'h021, 32'h0, 5'd14, lat);
        check("to_no_beat1_cycles", 32'(req_cycles - rc), 32'd255);
        check("to_no_beats", 32'(beat_q.size() - base), 32'd0);
        rv_mode = 2'd0;

        // Illegal size never touches memory.
        rc = req_cycles;
        access(1'b1, 2'b11, 1'b0, 11'h030, 32'h0, 5'd15, lat);
        check("ill_no_mem_req", 32'(req_cycles - rc), 32'd0);

        // Reset in the middle of beat 0; a late rvalid must not produce a response.
        rv_mode = 2'd2;
        wait_ready();
        req_valid_i = 1'b1; req_wen_i = 1'b1; req_size_i = 2'b10; req_addr_i = 11'h040; req_rd_i = 5'd16;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        check("mrst_in_beat", 32'(mem_req_o), 32'd1);
        reset_i = 1'b0;
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        check("mrst_mem_req", 32'(mem_req_o), 32'd0);
        check("mrst_ready", 32'(req_ready_o), 32'd1);
        check("mrst_err_cleared", 32'(rsp_err_o), 32'd0);
        rv_force = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            check("mrst_no_rsp", 32'(rsp_valid_o), 32'd0);
        end
        @(posedge clk_i); #1;
        rv_force = 1'b0;
        rv_mode = 2'd0;

        // Mixed traffic with random memory wait states.
        rv_mode = 2'd1;
        for (int k = 0; k < 40; k++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            ad = $urandom_range(0, 1) ? 11'($urandom_range(0, 31)) : 11'(2016 + $urandom_range(0, 31));
            access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom, 5'($urandom_range(0, 31)), lat);
        end
        rv_mode = 2'd0;

        repeat (2) @(posedge clk_i);
        check("scoreboard_empty", 32'(rsp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
